// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: default widths,
// sequencer state encoding and instruction optype codes.
package instr_sequencer_pkg;

   // Default widths used by the sequencer and its program-counter unit.
   localparam int SEQ_INSTR_W  = 32;
   localparam int SEQ_PC_W     = 8;
   localparam int SEQ_OPTYPE_W = 3;

   // Sequencer states; encoding is fixed so state values stay stable in traces.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_PRINT  = 3'd5
   } seq_state_e;

   // Instruction optype codes, carried in instr[2:0].
   localparam logic [2:0] OPT_P = 3'b000;
   localparam logic [2:0] OPT_R = 3'b001;
   localparam logic [2:0] OPT_I = 3'b010;
   localparam logic [2:0] OPT_S = 3'b011;
   localparam logic [2:0] OPT_B = 3'b100;
   localparam logic [2:0] OPT_U = 3'b101;
   localparam logic [2:0] OPT_J = 3'b110;
   localparam logic [2:0] OPT_A = 3'b111;

   // Only branches and jumps may redirect the program counter.
   function automatic logic is_redirect_op(input logic [2:0] optype);
      return (optype == OPT_B) || (optype == OPT_J);
   endfunction

endpackage

// File: rtl/instr_sequencer_pc_unit.sv
// Program counter for the instruction sequencer. Holds pc, the pending
// branch flag and branch target captured in EXEC, and selects the next pc
// (redirect target or pc+1 with natural wrap) on retire.
module instr_sequencer_pc_unit
   import instr_sequencer_pkg::*;
#(
   parameter int PC_W     = SEQ_PC_W,
   parameter int OPTYPE_W = SEQ_OPTYPE_W
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                exec_cap,
   input  logic                retire,
   input  logic                br_taken,
   input  logic [OPTYPE_W-1:0] optype,
   input  logic [PC_W-1:0]     br_target,
   output logic [PC_W-1:0]     pc
);

   logic [PC_W-1:0] pc_r;
   logic            br_pend_r;
   logic [PC_W-1:0] br_q_r;
   logic            take_s;
   logic            pend_eff_s;
   logic [PC_W-1:0] tgt_eff_s;
   logic [PC_W-1:0] pc_inc_s;
   logic [PC_W-1:0] pc_nxt_s;

   // Resolve the redirect decision; a plain branch retires in the same EXEC
   // cycle that captures it, so the fresh capture is forwarded to the mux.
   always_comb begin
      take_s   = br_taken & is_redirect_op(optype[2:0]);
      pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      if (exec_cap) begin
         pend_eff_s = take_s;
         tgt_eff_s  = br_target;
      end else begin
         pend_eff_s = br_pend_r;
         tgt_eff_s  = br_q_r;
      end
      if (pend_eff_s) begin
         pc_nxt_s = tgt_eff_s;
      end else begin
         pc_nxt_s = pc_inc_s;
      end
   end

   // Advance pc on retire and hold the branch capture between EXEC and retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r      <= {PC_W{1'b0}};
         br_pend_r <= 1'b0;
         br_q_r    <= {PC_W{1'b0}};
      end else if (retire) begin
         pc_r      <= pc_nxt_s;
         br_pend_r <= 1'b0;
      end else if (exec_cap) begin
         br_pend_r <= take_s;
         br_q_r    <= br_target;
      end else begin
         br_pend_r <= br_pend_r;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, then either
// writeback, print or retire directly. One instruction in flight at a time.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int INSTR_W  = SEQ_INSTR_W,
   parameter int PC_W     = SEQ_PC_W,
   parameter int OPTYPE_W = SEQ_OPTYPE_W
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop_req,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_q,
   input  logic               dec_reg_write,
   input  logic               dec_print,
   input  logic               br_taken,
   input  logic [PC_W-1:0]    br_target,
   output logic               alu_en,
   output logic               rf_we,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               retire,
   output logic               busy
);

   localparam logic [2:0] ST_IDLE   = S_IDLE;
   localparam logic [2:0] ST_FETCH  = S_FETCH;
   localparam logic [2:0] ST_DECODE = S_DECODE;
   localparam logic [2:0] ST_EXEC   = S_EXEC;
   localparam logic [2:0] ST_WB     = S_WB;
   localparam logic [2:0] ST_PRINT  = S_PRINT;

   logic [2:0]          state_r;
   logic [2:0]          state_nxt_s;
   logic                stop_pend_r;
   logic [INSTR_W-1:0]  instr_r;
   logic                retire_s;
   logic                exec_cap_s;
   logic                busy_s;
   logic [PC_W-1:0]     pc_s;
   logic [OPTYPE_W-1:0] optype_s;

   assign optype_s   = instr_r[OPTYPE_W-1:0];
   assign busy_s     = (state_r != ST_IDLE);
   assign exec_cap_s = (state_r == ST_EXEC);

   // Next-state selection and retire detection; every completing path funnels
   // through retire_s so the stop decision is made in one place.
   always_comb begin
      state_nxt_s = state_r;
      retire_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               state_nxt_s = ST_DECODE;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            state_nxt_s = ST_EXEC;
         end
         ST_EXEC: begin
            // Print wins over writeback if the decoder ever raises both.
            if (dec_print) begin
               state_nxt_s = ST_PRINT;
            end else if (dec_reg_write) begin
               state_nxt_s = ST_WB;
            end else begin
               retire_s = 1'b1;
            end
         end
         ST_WB: begin
            retire_s = 1'b1;
         end
         ST_PRINT: begin
            if (out_ready) begin
               retire_s = 1'b1;
            end else begin
               state_nxt_s = ST_PRINT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if (retire_s) begin
         if (stop_pend_r || stop_req) begin
            state_nxt_s = ST_IDLE;
         end else begin
            state_nxt_s = ST_FETCH;
         end
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Sticky stop request: collected while busy, consumed by the next retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_pend_r <= 1'b0;
      end else if (retire_s) begin
         stop_pend_r <= 1'b0;
      end else if (busy_s && stop_req) begin
         stop_pend_r <= 1'b1;
      end else begin
         stop_pend_r <= stop_pend_r;
      end
   end

   // Instruction register: loads only on a fetch handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_r <= {INSTR_W{1'b0}};
      end else if ((state_r == ST_FETCH) && imem_ack) begin
         instr_r <= imem_rdata;
      end else begin
         instr_r <= instr_r;
      end
   end

   instr_sequencer_pc_unit #(
      .PC_W     (PC_W),
      .OPTYPE_W (OPTYPE_W)
   ) u_pc_unit (
      .clk       (clk),
      .rst_n     (rst_n),
      .exec_cap  (exec_cap_s),
      .retire    (retire_s),
      .br_taken  (br_taken),
      .optype    (optype_s),
      .br_target (br_target),
      .pc        (pc_s)
   );

   // Strobes decode straight from the state register.
   assign imem_req  = (state_r == ST_FETCH);
   assign imem_addr = pc_s;
   assign instr_q   = instr_r;
   assign alu_en    = (state_r == ST_EXEC);
   assign rf_we     = (state_r == ST_WB);
   assign out_valid = (state_r == ST_PRINT);
   assign retire    = retire_s;
   assign busy      = busy_s;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: memory responder, decoder model
// and print sink driven per cycle, a vector table of single instructions and
// a few hand-written multi-cycle sequences.
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   localparam int IW = 32;
   localparam int PW = 8;

   logic          clk, rst_n, start, stop_req;
   logic          imem_req, imem_ack;
   logic [PW-1:0] imem_addr, br_target;
   logic [IW-1:0] imem_rdata, instr_q;
   logic          dec_reg_write, dec_print, br_taken;
   logic          alu_en, rf_we, out_valid, out_ready, retire, busy;

   instr_sequencer #(.INSTR_W(IW), .PC_W(PW), .OPTYPE_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr_q(instr_q),
      .dec_reg_write(dec_reg_write), .dec_print(dec_print),
      .br_taken(br_taken), .br_target(br_target),
      .alu_en(alu_en), .rf_we(rf_we), .out_valid(out_valid),
      .out_ready(out_ready), .retire(retire), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] opt;
      int         ack_dly;
      int         rdy_dly;
      logic       br_tk;
      logic [7:0] br_tgt;
      logic       both;
      int         exp_lat;
      logic [7:0] exp_pc;
      int         exp_rf;
      int         exp_val;
   } vec_t;

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] instr;
   } sb_t;

   vec_t        vecs[11];
   sb_t         sb_q[$];
   logic [31:0] mem[256];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int req_cnt, val_cnt, ack_dly, rdy_dly;
   int n_req, n_val, n_rf, n_alu, ret_cyc, start_cyc;
   logic seen_ret, addr_moved, stray_ack, force_both;
   logic [7:0] req_addr;
   logic [7:0] pc_model;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // One clock cycle: respond to the DUT just after the edge, then sample.
   task automatic step();
      logic [2:0] op;
      sb_t        e;
      @(posedge clk);
      #1;
      cyc++;
      if (imem_req) begin
         imem_ack   = (req_cnt >= ack_dly);
         imem_rdata = mem[imem_addr];
         if (req_cnt == 0) req_addr = imem_addr;
         else if (imem_addr != req_addr) addr_moved = 1'b1;
         req_cnt++;
         n_req++;
      end else begin
         imem_ack   = stray_ack;
         imem_rdata = 32'hFFFF_FFFF;
         req_cnt    = 0;
      end
      op            = instr_q[2:0];
      dec_print     = (op == OPT_P) || (op == OPT_A);
      dec_reg_write = force_both || (op == OPT_R) || (op == OPT_I) ||
                      (op == OPT_U) || (op == OPT_J);
      if (out_valid) begin
         out_ready = (val_cnt >= rdy_dly);
         val_cnt++;
         n_val++;
      end else begin
         out_ready = 1'b0;
         val_cnt   = 0;
      end
      if (rf_we)  n_rf++;
      if (alu_en) n_alu++;
      #1;
      if (retire) begin
         seen_ret = 1'b1;
         ret_cyc  = cyc;
         if (sb_q.size() == 0) begin
            check("sb_unexpected_retire", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_retire_pc", 64'(imem_addr), 64'(e.pc));
            check("sb_retire_instr", 64'(instr_q), 64'(e.instr));
         end
      end
   endtask

   task automatic wait_retire(input string name);
      int k;
      k = 0;
      seen_ret = 1'b0;
      while (!seen_ret && k < 60) begin
         step();
         k++;
      end
      check({name, "_retired"}, 64'(seen_ret), 64'd1);
   endtask

   function automatic logic [31:0] mk_instr(input int idx, input logic [2:0] opt);
      return {8'hA5, 8'(idx), 13'h0000, opt};
   endfunction

   task automatic run_vec(input int i);
      logic [31:0] ins;
      string       nm;
      nm  = $sformatf("v%0d", i);
      ins = mk_instr(i, vecs[i].opt);
      mem[pc_model] = ins;
      sb_q.push_back('{pc: pc_model, instr: ins});
      ack_dly = vecs[i].ack_dly;
      rdy_dly = vecs[i].rdy_dly;
      br_taken = vecs[i].br_tk;
      br_target = vecs[i].br_tgt;
      force_both = vecs[i].both;
      n_req = 0; n_val = 0; n_rf = 0; n_alu = 0; addr_moved = 1'b0;
      start = 1'b1;
      start_cyc = cyc;
      step();
      start = 1'b0;
      stop_req = 1'b1;
      step();
      stop_req = 1'b0;
      wait_retire(nm);
      check({nm, "_latency"}, 64'(ret_cyc - start_cyc), 64'(vecs[i].exp_lat));
      step();
      check({nm, "_next_pc"}, 64'(imem_addr), 64'(vecs[i].exp_pc));
      check({nm, "_busy_after"}, 64'(busy), 64'd0);
      step();
      check({nm, "_req_cycles"}, 64'(n_req), 64'(vecs[i].ack_dly + 1));
      check({nm, "_addr_stable"}, 64'(addr_moved), 64'd0);
      check({nm, "_alu_cycles"}, 64'(n_alu), 64'd1);
      check({nm, "_rf_cycles"}, 64'(n_rf), 64'(vecs[i].exp_rf));
      check({nm, "_valid_cycles"}, 64'(n_val), 64'(vecs[i].exp_val));
      force_both = 1'b0;
      br_taken = 1'b0;
      pc_model = vecs[i].exp_pc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int k;
      logic [31:0] ins4, ins5, ins6;
      vecs[0]  = '{3'b001, 0, 0, 1'b0, 8'h00, 1'b0, 4, 8'h01, 1, 0};
      vecs[1]  = '{3'b011, 3, 0, 1'b0, 8'h00, 1'b0, 6, 8'h02, 0, 0};
      vecs[2]  = '{3'b000, 0, 5, 1'b0, 8'h00, 1'b0, 9, 8'h03, 0, 6};
      vecs[3]  = '{3'b100, 0, 0, 1'b1, 8'h40, 1'b0, 3, 8'h40, 0, 0};
      vecs[4]  = '{3'b010, 0, 0, 1'b1, 8'h10, 1'b0, 4, 8'h41, 1, 0};
      vecs[5]  = '{3'b110, 0, 0, 1'b1, 8'hFF, 1'b0, 4, 8'hFF, 1, 0};
      vecs[6]  = '{3'b101, 0, 0, 1'b0, 8'h00, 1'b0, 4, 8'h00, 1, 0};
      vecs[7]  = '{3'b111, 1, 2, 1'b1, 8'h20, 1'b0, 7, 8'h01, 0, 3};
      vecs[8]  = '{3'b100, 0, 0, 1'b0, 8'h80, 1'b0, 3, 8'h02, 0, 0};
      vecs[9]  = '{3'b011, 0, 0, 1'b1, 8'h77, 1'b0, 3, 8'h03, 0, 0};
      vecs[10] = '{3'b000, 0, 0, 1'b0, 8'h00, 1'b1, 4, 8'h04, 0, 1};
      for (int a = 0; a < 256; a++) mem[a] = 32'h0000_0003;

      rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; imem_ack = 1'b0;
      imem_rdata = 32'h0; dec_reg_write = 1'b0; dec_print = 1'b0;
      br_taken = 1'b0; br_target = 8'h00; out_ready = 1'b0;
      req_cnt = 0; val_cnt = 0; ack_dly = 0; rdy_dly = 0;
      n_req = 0; n_val = 0; n_rf = 0; n_alu = 0; ret_cyc = 0; start_cyc = 0;
      seen_ret = 1'b0; addr_moved = 1'b0; stray_ack = 1'b0; force_both = 1'b0;
      req_addr = 8'h00; pc_model = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_pc", 64'(imem_addr), 64'd0);
      check("rst_instr_q", 64'(instr_q), 64'd0);
      check("rst_strobes", 64'({alu_en, rf_we, out_valid, retire}), 64'd0);
      rst_n = 1'b1;
      step();
      step();

      for (int i = 0; i < 11; i++) run_vec(i);

      // Acks while idle must not load the instruction register.
      stray_ack = 1'b1;
      repeat (3) step();
      stray_ack = 1'b0;
      check("stray_ack_instr_q", 64'(instr_q), 64'(mk_instr(10, 3'b000)));
      check("stray_ack_busy", 64'(busy), 64'd0);

      // Back-to-back: R then S without a stop in between.
      ins4 = mk_instr(20, OPT_R);
      ins5 = mk_instr(21, OPT_S);
      mem[8'h04] = ins4;
      mem[8'h05] = ins5;
      sb_q.push_back('{pc: 8'h04, instr: ins4});
      sb_q.push_back('{pc: 8'h05, instr: ins5});
      ack_dly = 0; rdy_dly = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_retire("b2b_first");
      step();
      check("b2b_refetch_req", 64'(imem_req), 64'd1);
      check("b2b_refetch_addr", 64'(imem_addr), 64'h05);
      stop_req = 1'b1;
      step();
      stop_req = 1'b0;
      wait_retire("b2b_second");
      step();
      check("b2b_idle", 64'(busy), 64'd0);
      check("b2b_pc", 64'(imem_addr), 64'h06);

      // Asynchronous reset while a print is waiting on the sink.
      ins6 = mk_instr(30, OPT_P);
      mem[8'h06] = ins6;
      sb_q.push_back('{pc: 8'h06, instr: ins6});
      rdy_dly = 100;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
         step();
         k++;
      end
      check("rstp_valid_before", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstp_valid", 64'(out_valid), 64'd0);
      check("rstp_busy", 64'(busy), 64'd0);
      check("rstp_pc", 64'(imem_addr), 64'd0);
      check("rstp_instr_q", 64'(instr_q), 64'd0);
      sb_q.delete();
      step();
      rst_n = 1'b1;
      rdy_dly = 0;
      n_req = 0;
      repeat (5) step();
      check("rstp_no_fetch", 64'(n_req), 64'd0);
      check("rstp_idle", 64'(busy), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
